clk_div_ctrl: RTL and testbench

//  Runtime-programmable clock divider controller. Generates a divided clock (div_clk) and a one-cycle

---
 rtl/clk_div_ctrl_pkg.sv | 17 +
 rtl/clk_div_period_cnt.sv | 18 +
 rtl/clk_div_ctrl.sv | 140 ++++++++++++++
 tb/tb_clk_div_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and helpers for the clk_div_ctrl runtime-programmable clock divider.
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DIV_MIN = 2;

  // Ratios below DIV_MIN cannot form a high and a low phase, so they are raised to DIV_MIN.
  function automatic logic [31:0] clamp_div(input logic [31:0] n);
    return (n < 32'(DIV_MIN)) ? 32'(DIV_MIN) : n;
  endfunction

endpackage

// File: rtl/clk_div_period_cnt.sv
// Period position counter for clk_div_ctrl: end-of-period detect, next count and high-phase compare.
module clk_div_period_cnt #(
  parameter int DIV_W = 12
) (
  input  logic [DIV_W-1:0] cnt,
  input  logic [DIV_W-1:0] n,
  input  logic             enable,
  output logic             last,
  output logic             high_nxt,
  output logic [DIV_W-1:0] cnt_nxt
);

  assign last     = enable && (cnt == (n - DIV_W'(1)));
  assign cnt_nxt  = (enable && !last) ? (cnt + DIV_W'(1)) : '0;
  // High phase covers the first floor(N/2) counts of each period.
  assign high_nxt = (cnt_nxt < (n >> 1));

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider: div_clk/div_tick from clk, ratio via a valid/ready config port.
// Optional tick counter (cnt_clr, tick_cnt) is built when CLK_DIV_CTRL_CNT_EN is defined.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int DIV_W   = 12,
  parameter int DEF_DIV = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CLK_DIV_CTRL_CNT_EN
  input  logic             cnt_clr,
  output logic [31:0]      tick_cnt,
`endif
  input  logic             run_en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             div_clk,
  output logic             div_tick,
  output logic [DIV_W-1:0] cur_div,
  output logic             active
);

  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(clamp_div(32'(DIV_W'(DEF_DIV))));

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             div_clk_q, div_clk_d;
  logic             div_tick_q, div_tick_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;

  logic             last;
  logic             high_nxt;
  logic [DIV_W-1:0] cnt_nxt;
  logic             accept;
  logic             apply;

  clk_div_period_cnt #(
    .DIV_W (DIV_W)
  ) u_period_cnt (
    .cnt      (cnt_q),
    .n        (cur_div_q),
    .enable   (state_q != ST_IDLE),
    .last     (last),
    .high_nxt (high_nxt),
    .cnt_nxt  (cnt_nxt)
  );

  // Config port: a transfer happens on cfg_valid && cfg_ready, and cfg_ready is low while a
  // ratio is pending, so at most one is held. A pending ratio is applied while idle or on the
  // last cycle of a period, which keeps accept and apply in different cycles.
  always_comb begin
    accept     = cfg_valid && !pend_vld_q;
    apply      = pend_vld_q && ((state_q == ST_IDLE) || last);
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    cur_div_d  = cur_div_q;
    if (apply) begin
      cur_div_d  = pend_div_q;
      pend_vld_d = 1'b0;
    end else if (accept) begin
      pend_div_d = DIV_W'(clamp_div(32'(cfg_div)));
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_nxt;
    div_clk_d  = high_nxt;
    div_tick_d = last;
    case (state_q)
      ST_IDLE: begin
        div_clk_d  = run_en;
        div_tick_d = run_en;
        if (run_en) state_d = ST_RUN;
      end
      default: begin
        // Stopping only happens at the period boundary; a stop there ends with div_clk low.
        if (run_en) begin
          state_d = ST_RUN;
        end else if (last) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          div_clk_d  = 1'b0;
          div_tick_d = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_clk_q  <= 1'b0;
      div_tick_q <= 1'b0;
      cur_div_q  <= DEF_N;
      pend_div_q <= DEF_N;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_clk_q  <= div_clk_d;
      div_tick_q <= div_tick_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign cfg_ready = !pend_vld_q;
  assign div_clk   = div_clk_q;
  assign div_tick  = div_tick_q;
  assign cur_div   = cur_div_q;
  assign active    = (state_q != ST_IDLE);

`ifdef CLK_DIV_CTRL_CNT_EN
  logic [31:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (cnt_clr) tick_cnt_d = '0;
    else if (div_tick_q) tick_cnt_d = tick_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed vector table, reset/counter sequences, random run.
module tb_clk_div_ctrl;

  localparam int DIV_W   = 12;
  localparam int DEF_DIV = 2048;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run_en;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             div_clk;
  logic             div_tick;
  logic [DIV_W-1:0] cur_div;
  logic             active;
`ifdef CLK_DIV_CTRL_CNT_EN
  logic             cnt_clr;
  logic [31:0]      tick_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: whether a period is running, position inside it, ratio in effect,
  // and the queue of accepted-but-not-yet-applied ratios.
  bit m_running;
  int m_pos;
  int m_n;
  int pend_q[$];

  typedef struct {
    string tag;
    bit    r;
    bit    v;
    int    d;
    bit    e_clk;
    bit    e_tick;
    bit    e_act;
    bit    e_rdy;
    int    e_cur;
  } vec_t;

  vec_t vecs[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  clk_div_ctrl #(
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CLK_DIV_CTRL_CNT_EN
    .cnt_clr   (cnt_clr),
    .tick_cnt  (tick_cnt),
`endif
    .run_en    (run_en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .div_clk   (div_clk),
    .div_tick  (div_tick),
    .cur_div   (cur_div),
    .active    (active)
  );

  // ---------------- helpers ----------------
  function automatic int clamp_n(input int n);
    return (n < 2) ? 2 : n;
  endfunction

  function automatic logic [31:0] pack_out();
    return {16'd0, div_clk, div_tick, active, cfg_ready, cur_div};
  endfunction

  function automatic logic [31:0] pack_exp(input bit c, input bit t, input bit a, input bit r,
                                           input int cur);
    return {16'd0, c, t, a, r, DIV_W'(cur)};
  endfunction

  function automatic void add_vec(input string tag, input bit r, input bit v, input int d,
                                  input bit c, input bit t, input bit a, input bit rd,
                                  input int cur);
    vec_t x;
    x.tag = tag; x.r = r; x.v = v; x.d = d;
    x.e_clk = c; x.e_tick = t; x.e_act = a; x.e_rdy = rd; x.e_cur = cur;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 1'b0;
    m_pos     = 0;
    m_n       = clamp_n(DEF_DIV % (1 << DIV_W));
    pend_q.delete();
  endtask

  // One clk edge of the model, using the inputs that were stable before the edge.
  task automatic model_step();
    bit acc;
    acc = cfg_valid && (pend_q.size() == 0);
    if (m_running && (m_pos != m_n - 1)) begin
      m_pos++;
    end else begin
      // Idle or period boundary: a pending ratio takes effect, then run_en decides.
      if (pend_q.size() != 0) m_n = pend_q.pop_front();
      m_running = run_en;
      m_pos     = 0;
    end
    if (acc) pend_q.push_back(clamp_n(int'(cfg_div)));
  endtask

  task automatic check_model(input string name);
    check(name, pack_out(),
          pack_exp(m_running && (m_pos < m_n / 2), m_running && (m_pos == 0),
                   m_running, pend_q.size() == 0, m_n));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit v, input int d);
    run_en    = r;
    cfg_valid = v;
    cfg_div   = DIV_W'(d);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------- test ----------------
  initial begin
    bit r_rand;
    bit v_rand;
    int d_rand;

    // Directed vectors: inputs for one cycle, outputs expected after that edge.
    add_vec("t1_cfg4",   0, 1, 4, 0, 0, 0, 0, 2048);
    add_vec("t1_apply",  0, 0, 0, 0, 0, 0, 1, 4);
    add_vec("t1_start",  1, 0, 0, 1, 1, 1, 1, 4);
    add_vec("t1_p1",     1, 0, 0, 1, 0, 1, 1, 4);
    add_vec("t1_p2",     1, 0, 0, 0, 0, 1, 1, 4);
    add_vec("t1_p3",     1, 0, 0, 0, 0, 1, 1, 4);
    add_vec("t1_p0b",    1, 0, 0, 1, 1, 1, 1, 4);
    add_vec("t1_p1b",    1, 0, 0, 1, 0, 1, 1, 4);
    add_vec("t1_p2b",    1, 0, 0, 0, 0, 1, 1, 4);
    add_vec("t1_p3b",    1, 0, 0, 0, 0, 1, 1, 4);
    add_vec("t4_cfg0",   1, 1, 0, 1, 1, 1, 0, 4);
    add_vec("t4_hold1",  1, 0, 0, 1, 0, 1, 0, 4);
    add_vec("t4_hold2",  1, 0, 0, 0, 0, 1, 0, 4);
    add_vec("t4_hold3",  1, 0, 0, 0, 0, 1, 0, 4);
    add_vec("t4_apply",  1, 0, 0, 1, 1, 1, 1, 2);
    add_vec("t4_lo",     1, 0, 0, 0, 0, 1, 1, 2);
    add_vec("t4_hi",     1, 0, 0, 1, 1, 1, 1, 2);
    add_vec("t4_cfg1",   1, 1, 1, 0, 0, 1, 0, 2);
    add_vec("t4_apply1", 1, 0, 0, 1, 1, 1, 1, 2);
    add_vec("t4_drain",  0, 0, 0, 0, 0, 1, 1, 2);
    add_vec("t4_stop",   0, 0, 0, 0, 0, 0, 1, 2);
    add_vec("t2_cfg5",   0, 1, 5, 0, 0, 0, 0, 2);
    add_vec("t2_apply",  0, 0, 0, 0, 0, 0, 1, 5);
    add_vec("t2_start",  1, 0, 0, 1, 1, 1, 1, 5);
    add_vec("t2_p1",     1, 0, 0, 1, 0, 1, 1, 5);
    add_vec("t2_cfg3",   1, 1, 3, 0, 0, 1, 0, 5);
    add_vec("t2_p3",     1, 0, 0, 0, 0, 1, 0, 5);
    add_vec("t2_p4",     1, 0, 0, 0, 0, 1, 0, 5);
    add_vec("t2_apply3", 1, 0, 0, 1, 1, 1, 1, 3);
    add_vec("t2_n3p1",   1, 0, 0, 0, 0, 1, 1, 3);
    add_vec("t2_n3p2",   1, 0, 0, 0, 0, 1, 1, 3);
    add_vec("t2_n3p0",   1, 0, 0, 1, 1, 1, 1, 3);
    add_vec("t3_cfg8",   1, 1, 8, 0, 0, 1, 0, 3);
    add_vec("t3_wait",   1, 0, 0, 0, 0, 1, 0, 3);
    add_vec("t3_apply8", 1, 0, 0, 1, 1, 1, 1, 8);
    add_vec("t3_p1",     1, 0, 0, 1, 0, 1, 1, 8);
    add_vec("t3_p2",     1, 0, 0, 1, 0, 1, 1, 8);
    add_vec("t3_dr3",    0, 0, 0, 1, 0, 1, 1, 8);
    add_vec("t3_dr4",    0, 0, 0, 0, 0, 1, 1, 8);
    add_vec("t3_dr5",    0, 0, 0, 0, 0, 1, 1, 8);
    add_vec("t3_dr6",    0, 0, 0, 0, 0, 1, 1, 8);
    add_vec("t3_dr7",    0, 0, 0, 0, 0, 1, 1, 8);
    add_vec("t3_idle",   0, 0, 0, 0, 0, 0, 1, 8);
    add_vec("t3_idle2",  0, 0, 0, 0, 0, 0, 1, 8);
    add_vec("t3b_start", 1, 0, 0, 1, 1, 1, 1, 8);
    add_vec("t3b_p1",    1, 0, 0, 1, 0, 1, 1, 8);
    add_vec("t3b_p2",    1, 0, 0, 1, 0, 1, 1, 8);
    add_vec("t3b_dr3",   0, 0, 0, 1, 0, 1, 1, 8);
    add_vec("t3b_dr4",   0, 0, 0, 0, 0, 1, 1, 8);
    add_vec("t3b_dr5",   0, 0, 0, 0, 0, 1, 1, 8);
    add_vec("t3b_re6",   1, 0, 0, 0, 0, 1, 1, 8);
    add_vec("t3b_p7",    1, 0, 0, 0, 0, 1, 1, 8);
    add_vec("t3b_p0",    1, 0, 0, 1, 1, 1, 1, 8);
    add_vec("t3b_p1b",   1, 0, 0, 1, 0, 1, 1, 8);

    // ---- reset ----
    rst_n     = 1'b0;
    run_en    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
`ifdef CLK_DIV_CTRL_CNT_EN
    cnt_clr   = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", pack_out(), pack_exp(0, 0, 0, 1, 2048));
`ifdef CLK_DIV_CTRL_CNT_EN
    check("reset_tick_cnt", tick_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", pack_out(), pack_exp(0, 0, 0, 1, 2048));

    // ---- directed table ----
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].d);
      check(vecs[i].tag, pack_out(),
            pack_exp(vecs[i].e_clk, vecs[i].e_tick, vecs[i].e_act, vecs[i].e_rdy, vecs[i].e_cur));
    end

    // ---- async reset in the high phase with a ratio pending ----
    drive(1, 1, 6);
    check("t5_pending", pack_out(), pack_exp(1, 0, 1, 0, 8));
    #2 rst_n = 1'b0;
    #1 check("t5_async_rst", pack_out(), pack_exp(0, 0, 0, 1, 2048));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0);
    check("t5_discard1", pack_out(), pack_exp(0, 0, 0, 1, 2048));
    drive(0, 0, 0);
    check_model("t5_discard2");

`ifdef CLK_DIV_CTRL_CNT_EN
    // ---- tick counter: 10 periods at N=2, then clear against a live tick ----
    drive(0, 1, 2);
    drive(0, 0, 0);
    check_model("t6_cfg2");
    repeat (20) drive(1, 0, 0);
    check("t6_ten_ticks", tick_cnt, 32'd10);
    drive(0, 0, 0);
    check("t6_stopped", tick_cnt, 32'd10);
    drive(1, 0, 0);
    cnt_clr = 1'b1;
    drive(1, 0, 0);
    cnt_clr = 1'b0;
    check("t6_clr_wins", tick_cnt, 32'd0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    check("t6_resume", tick_cnt, 32'd1);
    check_model("t6_model");
`endif

    // ---- randomized run against the model ----
    r_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) r_rand = !r_rand;
      v_rand = ($urandom_range(0, 5) == 0);
      d_rand = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40))
                                           : int'($urandom_range(0, 9));
      drive(r_rand, v_rand, d_rand);
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
